// File: rtl/uart_sched_pkg.sv
// Shared types and Avalon register map for the UART host scheduler.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL,
    POLL_WAIT,
    WRITE,
    GUARD,
    RX_RD,
    RX_WAIT
  } state_t;

  localparam logic [3:0] ADDR_TXDATA = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_RXDATA = 4'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       last_grant,
  output logic [2:0]       grant_idx,
  output logic             grant_vld
);

  logic [7:0] req_ext;
  logic [2:0] cand;

  assign req_ext = 8'(req);

  // Walk offsets from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = 3'((int'(last_grant) + i) % N_REQ);
      if (req_ext[cand]) begin
        grant_idx = cand;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_host_sched.sv
// Schedules TX bytes from N_REQ requesters and RX interrupt reads onto one
// Avalon-MM UART core: poll status, write data, guard gap, RX read on IRQ edge.
module uart_host_sched
  import uart_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int GUARD_CYC = 2
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         rx_data_o,
  output logic               rx_valid_o,
  output logic [3:0]         avm_address_o,
  output logic               avm_read_o,
  output logic               avm_write_o,
  output logic [7:0]         avm_writedata_o,
  input  logic [7:0]         avm_readdata_i,
  input  logic               irq_i,
  output logic               busy_o,
  output logic [2:0]         grant_id_o
);

  state_t     state_q, state_d;
  logic       irq_q, rx_pend_q, tx_held_q, rx_valid_q;
  logic [2:0] last_grant_q, grant_q;
  logic [7:0] tx_byte_q, rx_data_q, sel_byte;
  logic [3:0] guard_cnt_q;
  logic [2:0] arb_idx;
  logic       arb_vld, irq_edge, rx_pend_eff, tx_grant;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (req_valid_i),
    .last_grant (last_grant_q),
    .grant_idx  (arb_idx),
    .grant_vld  (arb_vld)
  );

  // An edge seen this cycle counts as pending so RX wins a same-cycle tie with TX.
  assign irq_edge    = irq_i & ~irq_q;
  assign rx_pend_eff = rx_pend_q | irq_edge;
  assign tx_grant    = (state_q == IDLE) && !rx_pend_eff && arb_vld;

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == 3'(i)) sel_byte = req_data_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (rx_pend_eff) state_d = RX_RD;
                 else if (arb_vld) state_d = POLL;
      POLL:      state_d = POLL_WAIT;
      POLL_WAIT: if (avm_readdata_i[0]) state_d = WRITE;
                 else if (rx_pend_eff) state_d = RX_RD;
                 else state_d = POLL;
      WRITE:     state_d = GUARD;
      GUARD:     if (guard_cnt_q == 4'(GUARD_CYC - 1)) state_d = IDLE;
      RX_RD:     state_d = RX_WAIT;
      RX_WAIT:   state_d = tx_held_q ? POLL : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    avm_read_o      = 1'b0;
    avm_write_o     = 1'b0;
    avm_address_o   = ADDR_TXDATA;
    avm_writedata_o = '0;
    req_ready_o     = '0;
    busy_o          = (state_q != IDLE);
    unique case (state_q)
      POLL: begin
        avm_read_o    = 1'b1;
        avm_address_o = ADDR_STATUS;
      end
      WRITE: begin
        avm_write_o     = 1'b1;
        avm_address_o   = ADDR_TXDATA;
        avm_writedata_o = tx_byte_q;
        for (int i = 0; i < N_REQ; i++) req_ready_o[i] = (grant_q == 3'(i));
      end
      RX_RD: begin
        avm_read_o    = 1'b1;
        avm_address_o = ADDR_RXDATA;
      end
      default: ;
    endcase
  end

  // A held grant survives an RX detour and is released only by its write.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      irq_q        <= 1'b0;
      rx_pend_q    <= 1'b0;
      tx_held_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      tx_byte_q    <= '0;
      grant_q      <= '0;
      last_grant_q <= 3'(N_REQ - 1);
      guard_cnt_q  <= '0;
    end else begin
      irq_q      <= irq_i;
      rx_valid_q <= (state_q == RX_WAIT);
      if (irq_edge)                rx_pend_q <= 1'b1;
      else if (state_q == RX_WAIT) rx_pend_q <= 1'b0;
      if (state_q == RX_WAIT) rx_data_q <= avm_readdata_i;
      if (tx_grant) begin
        grant_q   <= arb_idx;
        tx_byte_q <= sel_byte;
        tx_held_q <= 1'b1;
      end
      if (state_q == WRITE) begin
        last_grant_q <= grant_q;
        tx_held_q    <= 1'b0;
      end
      guard_cnt_q <= (state_q == GUARD) ? guard_cnt_q + 4'd1 : 4'd0;
    end
  end

  assign grant_id_o = grant_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule
